// File: rtl/spike_env_handshake_if.sv
// Handshake bundle between the environment endpoint and the spiking network core.
// The slave side is the endpoint itself; the master side is the stimulus logic and the network.
interface spike_env_handshake_if #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 2,
   parameter int CNT_W = 8
);
   logic                   inj_valid;
   logic [N_IN-1:0]        inj_mask;
   logic                   inj_ready;
   logic [N_IN-1:0]        net_req_in;
   logic [N_IN-1:0]        net_ack_in;
   logic [N_OUT-1:0]       net_req_out;
   logic [N_OUT-1:0]       net_ack_out;
   logic                   cnt_clr;
   logic [N_OUT*CNT_W-1:0] spike_cnt;
   logic                   tmo_err;

   modport slave (
      input  inj_valid, inj_mask, net_ack_in, net_req_out, cnt_clr,
      output inj_ready, net_req_in, net_ack_out, spike_cnt, tmo_err
   );

   modport master (
      output inj_valid, inj_mask, net_ack_in, net_req_out, cnt_clr,
      input  inj_ready, net_req_in, net_ack_out, spike_cnt, tmo_err
   );
endinterface

// File: rtl/spike_env_handshake.sv
// Clocked endpoint for the asynchronous spiking core: 4-phase initiator on the input
// layer, per-channel 4-phase responder with saturating spike counters on the output layer.
//
// state  | meaning
// S_IDLE | ready for an injection; acks from the network are ignored
// S_RISE | req driven with latched mask, waiting for all masked acks high
// S_FALL | req released, waiting for all masked acks low
// S_ERR  | handshake timed out, req released, waiting for every ack low
module spike_env_handshake #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 2,
   parameter int CNT_W = 8,
   parameter int TMO_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   spike_env_handshake_if.slave  hs
);

   typedef enum logic [1:0] {S_IDLE, S_RISE, S_FALL, S_ERR} state_t;

   // Counter reaching all-ones on this edge is the timeout point.
   localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t                 state_q, state_d;
   logic [N_IN-1:0]        mask_q, mask_d;
   logic [N_IN-1:0]        req_q, req_d;
   logic [TMO_W-1:0]       tmo_q, tmo_d;
   logic                   tmo_hit;
   logic                   err_q;
   logic [N_IN-1:0]        ack_s1, ack_sync;
   logic [N_OUT-1:0]       rq_s1, rq_sync;
   logic [N_OUT-1:0]       ack_out_q;
   logic [CNT_W-1:0]       cnt_q [N_OUT];
   logic [N_OUT*CNT_W-1:0] cnt_flat;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_s1   <= '0;
         ack_sync <= '0;
         rq_s1    <= '0;
         rq_sync  <= '0;
      end else begin
         ack_s1   <= hs.net_ack_in;
         ack_sync <= ack_s1;
         rq_s1    <= hs.net_req_out;
         rq_sync  <= rq_s1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         mask_q  <= '0;
         req_q   <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         req_q   <= req_d;
         tmo_q   <= tmo_d;
         if (tmo_hit)
            err_q <= 1'b1;
         else if (hs.cnt_clr)
            err_q <= 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      req_d   = req_q;
      tmo_d   = tmo_q;
      tmo_hit = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (hs.inj_valid) begin
               mask_d = hs.inj_mask;
               if (hs.inj_mask != '0) begin
                  state_d = S_RISE;
                  req_d   = hs.inj_mask;
                  tmo_d   = '0;
               end
            end
         end
         S_RISE: begin
            if ((ack_sync & mask_q) == mask_q) begin
               state_d = S_FALL;
               req_d   = '0;
               tmo_d   = '0;
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_ERR;
               req_d   = '0;
               tmo_hit = 1'b1;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         S_FALL: begin
            if ((ack_sync & mask_q) == '0) begin
               state_d = S_IDLE;
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_ERR;
               req_d   = '0;
               tmo_hit = 1'b1;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         S_ERR: begin
            if (ack_sync == '0)
               state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            req_d   = '0;
         end
      endcase
   end

   // A clear coinciding with an increment leaves that one spike counted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_out_q <= '0;
         for (int k = 0; k < N_OUT; k++)
            cnt_q[k] <= '0;
      end else begin
         for (int k = 0; k < N_OUT; k++) begin
            if (rq_sync[k] && !ack_out_q[k]) begin
               ack_out_q[k] <= 1'b1;
               if (hs.cnt_clr)
                  cnt_q[k] <= CNT_ONE;
               else if (cnt_q[k] != CNT_MAX)
                  cnt_q[k] <= cnt_q[k] + CNT_ONE;
            end else begin
               if (!rq_sync[k] && ack_out_q[k])
                  ack_out_q[k] <= 1'b0;
               if (hs.cnt_clr)
                  cnt_q[k] <= '0;
            end
         end
      end
   end

   always_comb begin
      cnt_flat = '0;
      for (int k = 0; k < N_OUT; k++)
         cnt_flat[k*CNT_W +: CNT_W] = cnt_q[k];
   end

   assign hs.inj_ready   = (state_q == S_IDLE);
   assign hs.net_req_in  = req_q;
   assign hs.net_ack_out = ack_out_q;
   assign hs.spike_cnt   = cnt_flat;
   assign hs.tmo_err     = err_q;

endmodule

// File: tb/tb_spike_env_handshake.sv
// Directed bench for spike_env_handshake with a cycle-level reference model checked every cycle.
module tb_spike_env_handshake;

   logic clk;
   logic rst;
   bit   chk_en;
   int   checks;
   int   errors;

   spike_env_handshake_if #(.N_IN(4), .N_OUT(2), .CNT_W(8)) hs ();

   spike_env_handshake #(.N_IN(4), .N_OUT(2), .CNT_W(8), .TMO_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .hs  (hs.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: acks are seen two edges late; phase 0 idle, 1 raising, 2 releasing, 3 error.
   int         m_ph;
   int         m_wait;
   logic [3:0] m_mask, m_req, ah1, ah2, seen_ack;
   logic [1:0] rh1, rh2, seen_req, m_ack;
   bit         m_err, done, set_err;
   int         m_cnt [2];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_ph = 0; m_wait = 0; m_mask = '0; m_req = '0; m_err = 0;
         ah1 = '0; ah2 = '0; rh1 = '0; rh2 = '0; m_ack = '0;
         m_cnt[0] = 0; m_cnt[1] = 0;
      end else begin
         seen_ack = ah2; seen_req = rh2;
         ah2 = ah1; ah1 = hs.net_ack_in;
         rh2 = rh1; rh1 = hs.net_req_out;
         set_err = 0;
         case (m_ph)
            0: if (hs.inj_valid && hs.inj_mask != 4'b0) begin
                  m_mask = hs.inj_mask; m_req = hs.inj_mask; m_ph = 1; m_wait = 0;
               end
            1, 2: begin
               done = (m_ph == 1) ? ((seen_ack & m_mask) == m_mask) : ((seen_ack & m_mask) == 4'b0);
               if (done) begin
                  m_ph = (m_ph == 1) ? 2 : 0; m_req = '0; m_wait = 0;
               end else begin
                  m_wait++;
                  if (m_wait >= 255) begin
                     m_ph = 3; m_req = '0; set_err = 1;
                  end
               end
            end
            default: if (seen_ack == 4'b0) m_ph = 0;
         endcase
         if (set_err) m_err = 1;
         else if (hs.cnt_clr) m_err = 0;
         for (int k = 0; k < 2; k++) begin
            if (seen_req[k] && !m_ack[k]) begin
               m_ack[k] = 1'b1;
               m_cnt[k] = hs.cnt_clr ? 1 : ((m_cnt[k] < 255) ? m_cnt[k] + 1 : 255);
            end else begin
               if (!seen_req[k] && m_ack[k]) m_ack[k] = 1'b0;
               if (hs.cnt_clr) m_cnt[k] = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_req_in", hs.net_req_in, m_req);
         check("cyc_ack_out", hs.net_ack_out, m_ack);
         check("cyc_spike_cnt", hs.spike_cnt, {m_cnt[1][7:0], m_cnt[0][7:0]});
         check("cyc_tmo_err", hs.tmo_err, m_err);
         check("cyc_inj_ready", hs.inj_ready, m_ph == 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_req(input logic [3:0] val, input int lim, output int n);
      n = 0;
      while (hs.net_req_in !== val && n < lim) begin tick(); n++; end
      check("wait_req_in", hs.net_req_in, val);
   endtask

   task automatic wait_ready(input int lim, output int n);
      n = 0;
      while (hs.inj_ready !== 1'b1 && n < lim) begin tick(); n++; end
      check("wait_inj_ready", hs.inj_ready, 1'b1);
   endtask

   task automatic wait_err(input int lim, output int n);
      n = 0;
      while (hs.tmo_err !== 1'b1 && n < lim) begin tick(); n++; end
      check("wait_tmo_err", hs.tmo_err, 1'b1);
   endtask

   task automatic wait_ack(input logic [1:0] val, input int lim, output int n);
      n = 0;
      while (hs.net_ack_out !== val && n < lim) begin tick(); n++; end
      check("wait_ack_out", hs.net_ack_out, val);
   endtask

   int n, k;

   initial begin
      checks = 0; errors = 0; chk_en = 0;
      rst = 1'b0;
      hs.inj_valid = 0; hs.inj_mask = '0; hs.net_ack_in = '0; hs.net_req_out = '0; hs.cnt_clr = 0;
      tick();
      chk_en = 1;

      // T1: reset with random inputs
      for (int i = 0; i < 6; i++) begin
         hs.inj_valid = 1'($urandom); hs.inj_mask = 4'($urandom);
         hs.net_ack_in = 4'($urandom); hs.net_req_out = 2'($urandom); hs.cnt_clr = 1'($urandom);
         tick();
      end
      check("t1_req_in", hs.net_req_in, 4'b0);
      check("t1_ack_out", hs.net_ack_out, 2'b0);
      check("t1_spike_cnt", hs.spike_cnt, 16'h0);
      check("t1_tmo_err", hs.tmo_err, 1'b0);
      check("t1_inj_ready", hs.inj_ready, 1'b1);
      hs.inj_valid = 0; hs.inj_mask = '0; hs.net_ack_in = '0; hs.net_req_out = '0; hs.cnt_clr = 0;
      tick();
      rst = 1'b1;
      tick(); tick();

      // Empty mask is a no-op
      hs.inj_valid = 1; hs.inj_mask = 4'b0000; tick(); hs.inj_valid = 0;
      check("t2_nop_ready", hs.inj_ready, 1'b1);
      check("t2_nop_req", hs.net_req_in, 4'b0);

      // T2: mask 0101
      hs.inj_valid = 1; hs.inj_mask = 4'b0101; tick(); hs.inj_valid = 0; hs.inj_mask = '0;
      check("t2_req", hs.net_req_in, 4'b0101);
      check("t2_busy", hs.inj_ready, 1'b0);
      repeat (5) tick();
      hs.net_ack_in = 4'b0101;
      wait_req(4'b0000, 20, n);
      check("t2_fall_edges", n, 3);
      repeat (5) tick();
      hs.net_ack_in = 4'b0000;
      wait_ready(20, n);
      check("t2_idle_edges", n, 3);

      // T3: ch3 never acked -> timeout
      hs.inj_valid = 1; hs.inj_mask = 4'b1111; tick(); hs.inj_valid = 0; hs.inj_mask = '0;
      repeat (3) tick();
      hs.net_ack_in = 4'b0111;
      wait_err(300, k);
      check("t3_tmo_edges", 3 + k, 255);
      check("t3_req", hs.net_req_in, 4'b0);
      check("t3_in_err", hs.inj_ready, 1'b0);
      repeat (4) tick();
      check("t3_err_hold", hs.inj_ready, 1'b0);
      hs.net_ack_in = 4'b0000;
      wait_ready(20, n);
      check("t3_idle_edges", n, 3);
      check("t3_sticky", hs.tmo_err, 1'b1);
      hs.cnt_clr = 1; tick(); hs.cnt_clr = 0;
      check("t3_clr", hs.tmo_err, 1'b0);

      // T4: 300 cycles on ch1, 3 on ch0
      for (int i = 0; i < 300; i++) begin
         hs.net_req_out = (i < 3) ? 2'b11 : 2'b10;
         wait_ack(hs.net_req_out, 20, n);
         if (i == 0) check("t4_ack_edges", n, 3);
         hs.net_req_out = 2'b00;
         wait_ack(2'b00, 20, n);
      end
      check("t4_ch0", hs.spike_cnt[7:0], 8'd3);
      check("t4_ch1", hs.spike_cnt[15:8], 8'd255);

      // T5: clear coincides with ack rise on ch0
      hs.net_req_out = 2'b01;
      tick(); tick();
      hs.cnt_clr = 1; tick(); hs.cnt_clr = 0;
      check("t5_ack", hs.net_ack_out, 2'b01);
      check("t5_ch0", hs.spike_cnt[7:0], 8'd1);
      check("t5_ch1", hs.spike_cnt[15:8], 8'd0);
      hs.net_req_out = 2'b00;
      wait_ack(2'b00, 20, n);

      // T6: reset mid-RISE with an ack high
      hs.inj_valid = 1; hs.inj_mask = 4'b0011; tick(); hs.inj_valid = 0; hs.inj_mask = '0;
      tick(); tick();
      hs.net_ack_in = 4'b0001;
      repeat (4) tick();
      check("t6_pre_req", hs.net_req_in, 4'b0011);
      rst = 1'b0;
      #1;
      check("t6_req_drop", hs.net_req_in, 4'b0);
      check("t6_ready", hs.inj_ready, 1'b1);
      tick(); tick();
      rst = 1'b1;
      repeat (10) tick();
      check("t6_no_req", hs.net_req_in, 4'b0);
      check("t6_idle", hs.inj_ready, 1'b1);
      check("t6_no_count", hs.spike_cnt, 16'h0);
      hs.net_ack_in = 4'b0000;
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
